// File: rtl/lz4_block_sequencer.sv
// Parses the LZ4 block stream and meters compressed payload bytes into the core. Uncompressed payload bypasses the core to out_word.
// Latency: in_data reaches core_data/out_word combinationally. Backpressure: pops only when in_exists and the active sink (core_read/out_ready) allow.
// Build option LZ4_BLOCK_CHECKSUM_EN: each data block is followed by a 4-byte checksum, which is consumed and discarded.
module lz4_block_sequencer #(
    parameter int word_size = 8,
    parameter int CNT_W     = 22,
    parameter int BCNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_exists,
    output logic                 in_read,
    output logic [word_size-1:0] core_data,
    output logic                 core_exists,
    input  logic                 core_read,
    output logic                 core_last,
    output logic [word_size-1:0] out_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 block_done,
    output logic                 frame_done,
    output logic                 error,
    output logic [BCNT_W-1:0]    block_count
);

    localparam int HDR_W  = 4 * word_size;
    localparam int SIZE_W = HDR_W - 1;

`ifdef LZ4_BLOCK_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_DECIDE, S_FEED, S_COPY, S_END, S_ERR, S_CKSUM
    } state_t;
`else
    typedef enum logic [3:0] {
        S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_DECIDE, S_FEED, S_COPY, S_END, S_ERR
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                done_q, done_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;
    logic                finish;
    logic [SIZE_W-1:0]   size;
    logic                oversize;

    assign core_data   = in_data;
    assign out_word    = in_data;
    assign block_done  = done_q;
    assign frame_done  = frame_q;
    assign error       = err_q;
    assign block_count = bcnt_q;

    assign size     = hdr_q[SIZE_W-1:0];
    assign oversize = (size >> CNT_W) != '0;

    // Gated by reset_n so no pop can leak out while reset is held.
    always_comb begin
        in_read     = 1'b0;
        core_exists = 1'b0;
        core_last   = 1'b0;
        out_valid   = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_HDR0, S_HDR1, S_HDR2, S_HDR3: in_read = in_exists;
                S_FEED: begin
                    core_exists = in_exists;
                    in_read     = core_read & in_exists;
                    core_last   = (rem_q == CNT_W'(1));
                end
                S_COPY: begin
                    out_valid = in_exists;
                    in_read   = in_exists & out_ready;
                end
`ifdef LZ4_BLOCK_CHECKSUM_EN
                S_CKSUM: in_read = in_exists;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        hdr_d   = hdr_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        frame_d = frame_q;
        err_d   = err_q;
        finish  = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_HDR2, S_HDR3: begin
                if (in_read) begin
                    hdr_d   = {in_data, hdr_q[HDR_W-1:word_size]};
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            S_DECIDE: begin
                if (hdr_q == '0) begin
                    frame_d = 1'b1;
                    state_d = S_END;
                end else if (oversize) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (size == '0) begin
                    finish = 1'b1;
                end else begin
                    rem_d   = size[CNT_W-1:0];
                    state_d = hdr_q[HDR_W-1] ? S_COPY : S_FEED;
                end
            end
            S_FEED, S_COPY: begin
                if (in_read) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) finish = 1'b1;
                end
            end
`ifdef LZ4_BLOCK_CHECKSUM_EN
            S_CKSUM: begin
                if (in_read) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = S_HDR0;
                    end
                end
            end
`endif
            default: ;
        endcase
        // End of payload: the checksum (when present) is reused-counted in rem.
        if (finish) begin
`ifdef LZ4_BLOCK_CHECKSUM_EN
            rem_d   = CNT_W'(4);
            state_d = S_CKSUM;
`else
            done_d  = 1'b1;
            bcnt_d  = bcnt_q + 1'b1;
            state_d = S_HDR0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HDR0;
            rem_q   <= '0;
            hdr_q   <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            hdr_q   <= hdr_d;
            bcnt_q  <= bcnt_d;
            done_q  <= done_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lz4_block_sequencer.sv
// Directed bench for lz4_block_sequencer, built with CNT_W=4 so the oversize path is reachable.
module tb_lz4_block_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_exists;
    logic       in_read;
    logic [7:0] core_data;
    logic       core_exists;
    logic       core_read;
    logic       core_last;
    logic [7:0] out_word;
    logic       out_valid;
    logic       out_ready;
    logic       block_done;
    logic       frame_done;
    logic       error;
    logic [15:0] block_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lz4_block_sequencer #(.word_size(8), .CNT_W(4), .BCNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_exists(in_exists), .in_read(in_read),
        .core_data(core_data), .core_exists(core_exists), .core_read(core_read),
        .core_last(core_last),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .block_done(block_done), .frame_done(frame_done), .error(error),
        .block_count(block_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops the 4 header bytes, LSB first; returns with the DUT in S_DECIDE.
    task automatic send_hdr(input logic [31:0] h);
        for (int k = 0; k < 4; k++) begin
            in_data   = h[8*k +: 8];
            in_exists = 1'b1;
            #1;
            chk("hdr_pop", in_read, 1);
            step();
        end
        in_exists = 1'b0;
    endtask

    logic [7:0] pl [5];
    logic [7:0] cp_dat [5];
    logic       cp_rdy [5];

    initial begin
        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_exists = 1'b1;
        core_read = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("rst_in_read", in_read, 0);
        chk("rst_core_exists", core_exists, 0);
        chk("rst_core_last", core_last, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_error", error, 0);
        chk("rst_block_count", block_count, 0);
        step();
        step();
        reset_n   = 1'b1;
        in_exists = 1'b0;
        core_read = 1'b0;

`ifdef LZ4_BLOCK_CHECKSUM_EN
        send_hdr(32'h0000_0002);
        step();
        core_read = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data   = 8'h40 + 8'(i);
            in_exists = 1'b1;
            #1;
            chk("ck_core_exists", core_exists, 1);
            chk("ck_core_data", core_data, 8'h40 + 8'(i));
            chk("ck_core_last", core_last, (i == 1));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hC0 + 8'(i);
            #1;
            chk("ck_sum_pop", in_read, 1);
            chk("ck_sum_core_exists", core_exists, 0);
            chk("ck_sum_block_done", block_done, 0);
            step();
        end
        in_exists = 1'b0;
        #1;
        chk("ck_block_done", block_done, 1);
        chk("ck_block_count", block_count, 1);
        send_hdr(32'h0000_0000);
        step();
        chk("ck_frame_done", frame_done, 1);
`else
        // Compressed 5-byte block with core_read held high.
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_hdr(32'h0000_0005);
        in_exists = 1'b1;
        in_data   = 8'h11;
        core_read = 1'b1;
        #1;
        chk("decide_no_pop", in_read, 0);
        chk("decide_core_exists", core_exists, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            in_data = pl[i];
            #1;
            chk("c_core_exists", core_exists, 1);
            chk("c_core_data", core_data, pl[i]);
            chk("c_core_last", core_last, (i == 4));
            chk("c_in_read", in_read, 1);
            step();
        end
        in_exists = 1'b0;
        #1;
        chk("c_block_done", block_done, 1);
        chk("c_block_count", block_count, 1);
        chk("c_core_exists_after", core_exists, 0);
        step();
        chk("c_block_done_pulse", block_done, 0);

        // FIFO starvation mid-payload.
        send_hdr(32'h0000_0004);
        step();
        for (int i = 0; i < 2; i++) begin
            in_data   = 8'h21 + 8'(i);
            in_exists = 1'b1;
            #1;
            chk("s_pop", in_read, 1);
            chk("s_core_last_early", core_last, 0);
            step();
        end
        in_exists = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s_starve_read", in_read, 0);
            chk("s_starve_exists", core_exists, 0);
            chk("s_starve_last", core_last, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            in_data   = 8'h23 + 8'(i);
            in_exists = 1'b1;
            #1;
            chk("s_resume_data", core_data, 8'h23 + 8'(i));
            chk("s_resume_last", core_last, (i == 1));
            step();
        end
        in_exists = 1'b0;
        #1;
        chk("s_block_done", block_done, 1);
        chk("s_block_count", block_count, 2);

        // Uncompressed block, out_ready toggling.
        cp_dat = '{8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC};
        cp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        send_hdr(32'h8000_0003);
        step();
        for (int i = 0; i < 5; i++) begin
            in_data   = cp_dat[i];
            out_ready = cp_rdy[i];
            in_exists = 1'b1;
            #1;
            chk("u_out_valid", out_valid, 1);
            chk("u_out_word", out_word, cp_dat[i]);
            chk("u_in_read", in_read, cp_rdy[i]);
            chk("u_core_exists", core_exists, 0);
            step();
        end
        in_exists = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("u_block_done", block_done, 1);
        chk("u_block_count", block_count, 3);
        chk("u_out_valid_after", out_valid, 0);

        // Uncompressed empty block completes straight from the header.
        send_hdr(32'h8000_0000);
        step();
        chk("z_block_done", block_done, 1);
        chk("z_block_count", block_count, 4);

        // Reset in the middle of a 7-byte compressed block.
        send_hdr(32'h0000_0007);
        step();
        in_exists = 1'b1;
        in_data   = 8'h55;
        #1;
        chk("r_core_exists", core_exists, 1);
        chk("r_core_last", core_last, 0);
        reset_n = 1'b0;
        #1;
        chk("r_in_read", in_read, 0);
        chk("r_core_exists_rst", core_exists, 0);
        chk("r_block_count_rst", block_count, 0);
        chk("r_block_done_rst", block_done, 0);
        step();
        reset_n   = 1'b1;
        in_exists = 1'b0;
        send_hdr(32'h0000_0001);
        step();
        in_exists = 1'b1;
        in_data   = 8'h66;
        #1;
        chk("r_fresh_last", core_last, 1);
        chk("r_fresh_read", in_read, 1);
        step();
        in_exists = 1'b0;
        #1;
        chk("r_fresh_done", block_done, 1);
        chk("r_fresh_count", block_count, 1);

        // Oversize: 16 exceeds 2^4-1.
        send_hdr(32'h0000_0010);
        in_exists = 1'b1;
        #1;
        chk("o_decide_read", in_read, 0);
        step();
        chk("o_error", error, 1);
        #1;
        chk("o_no_pop", in_read, 0);
        step();
        chk("o_error_hold", error, 1);
        chk("o_no_pop_hold", in_read, 0);
        chk("o_count", block_count, 1);
        chk("o_block_done", block_done, 0);
        reset_n = 1'b0;
        #1;
        chk("o_error_rst", error, 0);
        step();
        reset_n   = 1'b1;
        in_exists = 1'b0;

        // End mark.
        send_hdr(32'h0000_0000);
        in_exists = 1'b1;
        #1;
        chk("e_decide_read", in_read, 0);
        step();
        chk("e_frame_done", frame_done, 1);
        chk("e_error", error, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("e_no_pop", in_read, 0);
            step();
            chk("e_frame_hold", frame_done, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lz4_block_sequencer.md
Name: lz4_block_sequencer

Overview:
- Sits between the compressed-input FIFO and the LZ4 decompression core.
- Parses the LZ4 frame block stream: a 4-byte little-endian block-size word, then a payload.
- Compressed payloads are metered byte-for-byte into the core. Uncompressed payloads bypass the core to the output port. The end mark terminates the frame.
- Counts payload bytes, flags the final byte of each block to the core, and reports block/frame completion and errors.

Parameters:
- word_size, 8, byte width of the data path (the header is always 4 words).
- CNT_W, 22, width of the remaining-byte counter. Maximum legal block size is 2^CNT_W-1.
- BCNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  word_size  head byte of the compressed-input FIFO. Valid while in_exists=1.
- in_exists  input  1  FIFO non-empty.
- in_read  output  word_size=1  pop strobe to the FIFO. Combinational; pops in_data this cycle.
- core_data  output  word_size  byte to the core. Wired to in_data.
- core_exists  output  1  core_data valid for the core.
- core_read  input  1  core pop strobe. Honoured only when core_exists=1.
- core_last  output  1  core_data is the final byte of the current compressed block.
- out_word  output  word_size  bypass (uncompressed) byte.
- out_valid  output  1  out_word valid.
- out_ready  input  1  sink accepts out_word this cycle.
- block_done  output  1  one-cycle pulse after the last payload byte of any block.
- frame_done  output  1  level. End mark consumed.
- error  output  1  level. Oversize block.
- block_count  output  BCNT_W  number of completed blocks. Wraps modulo 2^BCNT_W.

Behaviour:
- Reset (async, reset_n=0): state=S_HDR0, remaining=0, size shift reg=0, block_count=0, frame_done=0, error=0, block_done=0. in_read, core_exists, core_last and out_valid are all 0. Reset mid-block abandons the block silently; no block_done is issued.
- S_HDR0..S_HDR3: in_read=in_exists. Each popped byte is shifted into hdr[8k+7:8k] for k=0..3, then the FSM advances. With no data, it holds.
- S_DECIDE (1 cycle, no pop): uncomp=hdr[31], size=hdr[30:0].
  - hdr==0: go to S_END.
  - size > 2^CNT_W-1: set error, go to S_ERR.
  - size==0 with uncomp=1: block_done pulse, block_count+1, go to S_HDR0.
  - Otherwise: remaining=size, then go to S_COPY if uncomp=1, else S_FEED.
- S_FEED:
  - core_exists=in_exists.
  - in_read=core_read & in_exists.
  - core_last=(remaining==1).
  - Each pop decrements remaining.
  - The pop at remaining==1 moves the FSM to S_HDR0 with a block_done pulse next cycle and block_count+1.
- S_COPY:
  - out_word=in_data, out_valid=in_exists.
  - in_read=in_exists & out_ready.
  - Decrement and exit exactly as in S_FEED.
  - core_exists=0.
- S_END: frame_done=1. No pops. Holds until reset.
- S_ERR: error=1. No pops. Holds until reset.
- Block size counts payload bytes only; header and optional checksum bytes are excluded.
- core_read or out_ready asserted with in_exists=0: no pop, no decrement.
- Zero-cycle bubble between blocks is not required; header parsing costs 5 cycles minimum (4 pops + S_DECIDE).
- Latency: in_data to core_data/out_word is combinational. No internal data buffering.

Optional Feature:
- LZ4_BLOCK_CHECKSUM_EN defined: after the last payload byte of every data block (not the end mark), the FSM enters S_CKSUM and pops and discards exactly 4 bytes. block_done pulses and block_count increments after the 4th checksum byte, then the FSM goes to S_HDR0.
- Not defined: S_CKSUM does not exist. The FSM goes directly to S_HDR0 after the payload.

Test Plan:
- Compressed block: header 05 00 00 00 + 5 bytes, core_read held 1 -> core_exists high for 5 pops, core_last on the 5th only, block_done pulse, block_count=1, core sees exactly the 5 bytes.
- Uncompressed block: header 03 00 00 80 + AA BB CC, out_ready toggling 1/0 -> out_word sequence AA,BB,CC with no pops while out_ready=0, core_exists stays 0, block_count=1.
- End mark: 00 00 00 00 -> frame_done=1, in_read stays 0 afterwards even with in_exists=1.
- Oversize block with CNT_W=4: header 10 00 00 00 -> error=1 after S_DECIDE, no payload pops.
- FIFO starvation: in_exists dropped for 3 cycles mid-payload -> remaining unchanged, no spurious core_last; the block completes correctly once data resumes.
- reset_n pulsed low mid-S_FEED with remaining=7 -> all outputs at reset values the same cycle; the next header parses as a fresh block, block_count=0.
- With LZ4_BLOCK_CHECKSUM_EN: block 02 00 00 00 + 2 bytes + 4 checksum bytes + end mark -> core receives 2 bytes only, block_done after the 10th pop, then frame_done=1.
